// File: rtl/wb_dma_handshake_pkg.sv
// Shared types and limits for the wb_dma hardware-handshake generator.
package wb_dma_handshake_pkg;

  localparam int MAX_CH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2,
    ST_ND   = 2'd3
  } hs_state_e;

  // Bits needed to hold any value in 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/wb_dma_handshake_chan.sv
// One handshake channel: request/ack sequencing, inter-request gap and optional ack timeout.
// WB_DMA_HANDSHAKE_TIMEOUT_EN adds an abort when a request sees no ack within TIMEOUT cycles.
module wb_dma_handshake_chan
  import wb_dma_handshake_pkg::*;
#(
  parameter int CNT_W   = 8,
`ifdef WB_DMA_HANDSHAKE_TIMEOUT_EN
  parameter int TIMEOUT = 256,
`endif
  parameter int REQ_GAP = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic             nd_en_i,
  input  logic             rest_i,
  input  logic             ack_i,
  output logic             req_o,
  output logic             nd_o,
  output logic             rest_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int GAP_W = cnt_width(REQ_GAP - 1);

  hs_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [GAP_W-1:0] gap_q;
  logic             nd_en_q;
  logic             req_q;
  logic             nd_q;
  logic             rest_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
`ifdef WB_DMA_HANDSHAKE_TIMEOUT_EN
  localparam int TMO_W = cnt_width(TIMEOUT - 1);
  logic [TMO_W-1:0] tmo_q;
`endif

  // Channel sequencer; each output register is loaded from the state being entered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      nd_en_q <= 1'b0;
      req_q   <= 1'b0;
      nd_q    <= 1'b0;
      rest_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef WB_DMA_HANDSHAKE_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      req_q  <= 1'b0;
      nd_q   <= 1'b0;
      rest_q <= 1'b0;
      done_q <= 1'b0;
`ifdef WB_DMA_HANDSHAKE_TIMEOUT_EN
      tmo_q  <= '0;
`endif
      if (rest_i) begin
        // Restart beats everything in the same cycle, an ack included.
        rest_q  <= 1'b1;
        busy_q  <= 1'b0;
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_i) begin
              err_q   <= 1'b0;
              nd_en_q <= nd_en_i;
              cnt_q   <= count_i;
              if (count_i == '0) begin
                done_q <= 1'b1;
              end else begin
                state_q <= ST_REQ;
                req_q   <= 1'b1;
                busy_q  <= 1'b1;
              end
            end else if (ack_i) begin
              err_q <= 1'b1;
            end
          end
          ST_REQ: begin
            if (ack_i) begin
              cnt_q <= cnt_q - CNT_W'(1);
              if (cnt_q == CNT_W'(1)) begin
                state_q <= ST_ND;
                done_q  <= 1'b1;
                nd_q    <= nd_en_q;
              end else begin
                state_q <= ST_GAP;
                gap_q   <= GAP_W'(REQ_GAP - 1);
              end
            end else begin
`ifdef WB_DMA_HANDSHAKE_TIMEOUT_EN
              if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                err_q   <= 1'b1;
                rest_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end else begin
                tmo_q <= tmo_q + TMO_W'(1);
                req_q <= 1'b1;
              end
`else
              req_q <= 1'b1;
`endif
            end
          end
          ST_GAP: begin
            if (ack_i) begin
              err_q <= 1'b1;
            end
            if (gap_q == '0) begin
              state_q <= ST_REQ;
              req_q   <= 1'b1;
            end else begin
              gap_q <= gap_q - GAP_W'(1);
            end
          end
          ST_ND: begin
            if (ack_i) begin
              err_q <= 1'b1;
            end
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign req_o  = req_q;
  assign nd_o   = nd_q;
  assign rest_o = rest_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: rtl/wb_dma_handshake_ctrl.sv
// Multi-channel DMA hardware-handshake generator: NUM_CH independent channels, no arbitration.
// WB_DMA_HANDSHAKE_TIMEOUT_EN enables the per-channel ack timeout of TIMEOUT cycles.
module wb_dma_handshake_ctrl
  import wb_dma_handshake_pkg::*;
#(
  parameter int NUM_CH  = 32,
  parameter int CNT_W   = 8,
  parameter int REQ_GAP = 1,
  parameter int TIMEOUT = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_CH-1:0]       cfg_start,
  input  logic [NUM_CH*CNT_W-1:0] cfg_count,
  input  logic [NUM_CH-1:0]       cfg_nd_en,
  input  logic [NUM_CH-1:0]       cfg_rest,
  output logic [NUM_CH-1:0]       dma_req,
  input  logic [NUM_CH-1:0]       dma_ack,
  output logic [NUM_CH-1:0]       dma_nd,
  output logic [NUM_CH-1:0]       dma_rest,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH-1:0]       err
);

  // Unsupported configurations stop elaboration rather than misbehave silently.
  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
    $error("wb_dma_handshake_ctrl: NUM_CH must be 1..32");
  end
  if (REQ_GAP < 1) begin : g_bad_gap
    $error("wb_dma_handshake_ctrl: REQ_GAP must be at least 1");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("wb_dma_handshake_ctrl: TIMEOUT must be at least 1");
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    wb_dma_handshake_chan #(
      .CNT_W   (CNT_W),
`ifdef WB_DMA_HANDSHAKE_TIMEOUT_EN
      .TIMEOUT (TIMEOUT),
`endif
      .REQ_GAP (REQ_GAP)
    ) u_chan (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (cfg_start[c]),
      .count_i (cfg_count[c*CNT_W +: CNT_W]),
      .nd_en_i (cfg_nd_en[c]),
      .rest_i  (cfg_rest[c]),
      .ack_i   (dma_ack[c]),
      .req_o   (dma_req[c]),
      .nd_o    (dma_nd[c]),
      .rest_o  (dma_rest[c]),
      .busy_o  (busy[c]),
      .done_o  (done[c]),
      .err_o   (err[c])
    );
  end

endmodule

// File: tb/tb_wb_dma_handshake_ctrl.sv
// Bench for wb_dma_handshake_ctrl: directed scenarios plus random traffic against a timeline model.
// Define WB_DMA_HANDSHAKE_TIMEOUT_EN for both RTL and bench to exercise the ack timeout.
`timescale 1ns/1ps
module tb_wb_dma_handshake_ctrl;

  localparam int NCH = 4;
  localparam int CW  = 4;
  localparam int GAP = 1;
  localparam int TMO = 16;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NCH-1:0]    cfg_start, cfg_nd_en, cfg_rest, dma_ack;
  logic [NCH*CW-1:0] cfg_count;
  logic [NCH-1:0]    dma_req, dma_nd, dma_rest, busy, done, err;

  wb_dma_handshake_ctrl #(
    .NUM_CH(NCH), .CNT_W(CW), .REQ_GAP(GAP), .TIMEOUT(TMO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cfg_start(cfg_start), .cfg_count(cfg_count), .cfg_nd_en(cfg_nd_en), .cfg_rest(cfg_rest),
    .dma_req(dma_req), .dma_ack(dma_ack), .dma_nd(dma_nd), .dma_rest(dma_rest),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk_i = ~clk_i;

  int nchecks = 0;
  int nerr    = 0;
  int edge_k  = 0;
  int mode    = 0;  // 0: random acks, 1: ack every request after one cycle, 2: no acks

  // Timeline model: a channel is active with `rem` transfers left; its request is
  // visible after every edge from req_from on; `fin` marks the cycle showing done.
  bit act[NCH];
  bit fin[NCH];
  bit ndm[NCH];
  bit errm[NCH];
  int rem[NCH];
  int req_from[NCH];
  int age[NCH];
  logic [NCH-1:0] exp_req = '0, exp_nd = '0, exp_rest = '0;
  logic [NCH-1:0] exp_busy = '0, exp_done = '0, exp_err = '0;

  int rise_cnt[NCH], done_cnt[NCH], nd_cnt[NCH], rest_cnt[NCH], tog_cnt[NCH], done_edge[NCH];
  logic [NCH-1:0]   prev_req = '0;
  logic [6*NCH-1:0] prev_all = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    nchecks++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, edge_k, got, want);
    end
  endtask

  task automatic model_step(input int c);
    bit was_req;
    was_req     = exp_req[c];
    exp_rest[c] = 1'b0;
    exp_done[c] = 1'b0;
    exp_nd[c]   = 1'b0;
    if (rst_i) begin
      act[c] = 1'b0; fin[c] = 1'b0; errm[c] = 1'b0;
    end else if (cfg_rest[c]) begin
      exp_rest[c] = 1'b1; act[c] = 1'b0; fin[c] = 1'b0;
    end else if (!act[c]) begin
      if (cfg_start[c]) begin
        errm[c] = 1'b0;
        if (cfg_count[c*CW +: CW] == 0) begin
          exp_done[c] = 1'b1;
        end else begin
          act[c] = 1'b1; fin[c] = 1'b0; rem[c] = int'(cfg_count[c*CW +: CW]);
          ndm[c] = cfg_nd_en[c]; req_from[c] = edge_k; age[c] = 0;
        end
      end else if (dma_ack[c]) begin
        errm[c] = 1'b1;
      end
    end else if (fin[c]) begin
      if (dma_ack[c]) errm[c] = 1'b1;
      act[c] = 1'b0; fin[c] = 1'b0;
    end else if (was_req) begin
      if (dma_ack[c]) begin
        rem[c]--; age[c] = 0;
        if (rem[c] == 0) begin
          fin[c] = 1'b1; exp_done[c] = 1'b1; exp_nd[c] = ndm[c];
        end else begin
          req_from[c] = edge_k + GAP;
        end
      end else begin
`ifdef WB_DMA_HANDSHAKE_TIMEOUT_EN
        age[c]++;
        if (age[c] == TMO) begin
          errm[c] = 1'b1; exp_rest[c] = 1'b1; act[c] = 1'b0;
        end
`endif
      end
    end else if (dma_ack[c]) begin
      errm[c] = 1'b1;
    end
    exp_req[c]  = act[c] && !fin[c] && (edge_k >= req_from[c]);
    exp_busy[c] = act[c];
    exp_err[c]  = errm[c];
  endtask

  task automatic observe();
    logic [6*NCH-1:0] now;
    now = {err, done, busy, dma_rest, dma_nd, dma_req};
    for (int c = 0; c < NCH; c++) begin
      if (dma_req[c] && !prev_req[c]) rise_cnt[c]++;
      if (done[c]) begin done_cnt[c]++; done_edge[c] = edge_k; end
      if (dma_nd[c]) nd_cnt[c]++;
      if (dma_rest[c]) rest_cnt[c]++;
      for (int b = 0; b < 6; b++) begin
        if (now[b*NCH+c] !== prev_all[b*NCH+c]) tog_cnt[c]++;
      end
    end
    prev_req = dma_req;
    prev_all = now;
  endtask

  // Advance the model at each sampling edge, then compare once outputs have settled.
  always @(posedge clk_i) begin
    edge_k++;
    for (int c = 0; c < NCH; c++) model_step(c);
    #1;
    chk("dma_req",  32'(dma_req),  32'(exp_req));
    chk("dma_nd",   32'(dma_nd),   32'(exp_nd));
    chk("dma_rest", 32'(dma_rest), 32'(exp_rest));
    chk("busy",     32'(busy),     32'(exp_busy));
    chk("done",     32'(done),     32'(exp_done));
    chk("err",      32'(err),      32'(exp_err));
    observe();
  end

  task automatic clear_counts();
    for (int c = 0; c < NCH; c++) begin
      rise_cnt[c] = 0; done_cnt[c] = 0; nd_cnt[c] = 0;
      rest_cnt[c] = 0; tog_cnt[c] = 0; done_edge[c] = -1;
    end
  endtask

  // One clock; on return (falling edge) pulses are cleared and the responder has driven acks.
  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
    cfg_start = '0;
    cfg_rest  = '0;
    for (int c = 0; c < NCH; c++) dma_ack[c] = (mode == 1) && exp_req[c];
  endtask

  function automatic logic [CW-1:0] pick_count();
    int r;
    r = int'($urandom % 16);
    if (r == 0) return '0;
    if (r == 1) return '1;
    return CW'(1 + ($urandom % 4));
  endfunction

  int s_edge;
  bit r_b, s_b;

  initial begin
    rst_i = 1'b1; cfg_start = '0; cfg_count = '0; cfg_nd_en = '0; cfg_rest = '0; dma_ack = '0;
    clear_counts();
    @(negedge clk_i);
    tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_req",  32'(dma_req), 32'd0);
    rst_i = 1'b0;
    mode  = 1;
    tick();

    // ch1: three transfers with next-descriptor, acked one cycle after each request
    clear_counts();
    cfg_count[1*CW +: CW] = 4'd3; cfg_nd_en = 4'b0010; cfg_start = 4'b0010;
    s_edge = edge_k + 1;
    repeat (10) tick();
    chk("ch1_req_pulses", rise_cnt[1], 32'd3);
    chk("ch1_done_pulses", done_cnt[1], 32'd1);
    chk("ch1_nd_pulses", nd_cnt[1], 32'd1);
    chk("ch1_done_offset", done_edge[1] - s_edge, 32'd5);
    chk("others_quiet", tog_cnt[0] + tog_cnt[2] + tog_cnt[3], 32'd0);

    // ch0: zero-count start completes at once without a request
    clear_counts();
    cfg_count[0 +: CW] = 4'd0; cfg_start = 4'b0001;
    tick();
    chk("ch0_zero_done", 32'(done[0]), 32'd1);
    chk("ch0_zero_busy", 32'(busy[0]), 32'd0);
    tick();
    chk("ch0_zero_done_once", 32'(done[0]), 32'd0);
    chk("ch0_zero_no_req", rise_cnt[0], 32'd0);

    // ch2: restart after the second ack
    clear_counts();
    cfg_count[2*CW +: CW] = 4'd5; cfg_start = 4'b0100;
    tick();
    repeat (3) tick();
    cfg_rest = 4'b0100;
    tick();
    chk("ch2_rest_pulse", 32'(dma_rest[2]), 32'd1);
    chk("ch2_rest_busy", 32'(busy[2]), 32'd0);
    repeat (3) tick();
    chk("ch2_rest_once", rest_cnt[2], 32'd1);
    chk("ch2_no_done", done_cnt[2], 32'd0);
    chk("ch2_no_nd", nd_cnt[2], 32'd0);

    // ch3: spurious ack while idle is sticky until the next start
    dma_ack[3] = 1'b1;
    tick();
    chk("ch3_err_set", 32'(err[3]), 32'd1);
    repeat (3) tick();
    chk("ch3_err_sticky", 32'(err[3]), 32'd1);
    cfg_count[3*CW +: CW] = 4'd1; cfg_start = 4'b1000;
    tick();
    chk("ch3_err_cleared", 32'(err[3]), 32'd0);
    repeat (4) tick();

    // ch1: a start in the first cycle busy reads 0 is accepted
    clear_counts();
    cfg_count[1*CW +: CW] = 4'd1; cfg_start = 4'b0010;
    repeat (3) tick();
    chk("b2b_idle", 32'(busy[1]), 32'd0);
    cfg_count[1*CW +: CW] = 4'd2; cfg_start = 4'b0010;
    tick();
    chk("b2b_busy", 32'(busy[1]), 32'd1);
    chk("b2b_req", 32'(dma_req[1]), 32'd1);
    repeat (8) tick();
    chk("b2b_done_pulses", done_cnt[1], 32'd2);

    // ch0: largest count runs the full number of transfers
    clear_counts();
    cfg_count[0 +: CW] = 4'd15; cfg_start = 4'b0001;
    repeat (40) tick();
    chk("max_req_pulses", rise_cnt[0], 32'd15);
    chk("max_done_pulses", done_cnt[0], 32'd1);

    // ch0: request without any ack
    mode = 2;
    cfg_count[0 +: CW] = 4'd1; cfg_start = 4'b0001;
    tick();
    repeat (TMO) tick();
`ifdef WB_DMA_HANDSHAKE_TIMEOUT_EN
    chk("tmo_rest", 32'(dma_rest[0]), 32'd1);
    chk("tmo_err", 32'(err[0]), 32'd1);
    chk("tmo_busy", 32'(busy[0]), 32'd0);
    chk("tmo_no_done", 32'(done[0]), 32'd0);
`else
    chk("wait_req", 32'(dma_req[0]), 32'd1);
    chk("wait_busy", 32'(busy[0]), 32'd1);
    cfg_rest = 4'b0001;
    tick();
    chk("wait_abort_busy", 32'(busy[0]), 32'd0);
`endif
    tick();

    // reset in the middle of requests clears everything
    cfg_count[1*CW +: CW] = 4'd3; cfg_count[2*CW +: CW] = 4'd5; cfg_start = 4'b0110;
    dma_ack[3] = 1'b1;
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    chk("rst_mid_req",  32'(dma_req), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_err",  32'(err), 32'd0);
    chk("rst_mid_misc", 32'({done, dma_nd, dma_rest}), 32'd0);
    rst_i = 1'b0;
    tick();

    // random traffic checked cycle by cycle against the model
    mode = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      for (int c = 0; c < NCH; c++) begin
        r_b = ($urandom % 40) == 0;
        s_b = !r_b && (($urandom % 6) == 0);
        cfg_rest[c]  = r_b;
        cfg_start[c] = s_b;
        cfg_count[c*CW +: CW] = pick_count();
        cfg_nd_en[c] = ($urandom % 2) == 0;
        if (exp_req[c]) dma_ack[c] = ($urandom % 2) == 0;
        else            dma_ack[c] = !r_b && !s_b && (($urandom % 25) == 0);
      end
    end
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
